// File: rtl/dsd_mem_pkg.sv
// rtl/dsd_mem_pkg.sv - shared types for the memory port arbiter
package dsd_mem_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_D = 3'd1,
    RD_I = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DC,
    GNT_IC,
    GNT_WB
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache-side and memory-side signals of the shared port
// master drives requests and memory responses; slave is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = dsd_mem_pkg::ADDR_W_DEF,
  parameter int LINE_W = dsd_mem_pkg::LINE_W_DEF
) ();

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ready;
  logic [LINE_W-1:0] ic_rdata;

  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic              dc_ready;
  logic [LINE_W-1:0] dc_rdata;

  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_wdata;
  logic              wb_full;
  logic              wb_ack;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output ic_req, ic_addr, dc_req, dc_addr,
    output wb_req, wb_addr, wb_wdata, wb_full,
    output mem_rdata, mem_ready,
    input  ic_ready, ic_rdata, dc_ready, dc_rdata, wb_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_addr,
    input  wb_req, wb_addr, wb_wdata, wb_full,
    input  mem_rdata, mem_ready,
    output ic_ready, ic_rdata, dc_ready, dc_rdata, wb_ack,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selector
// Read-over-write priority, except for a dc/wb address hazard or write starvation.
module mem_arb_pick
  import dsd_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              ic_req,
  input  logic              dc_req,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_full,
  input  logic [CNT_W-1:0]  starve_cnt,
  output gnt_e              grant
);

  always_comb begin
    grant = GNT_NONE;
    // A pending write to the line being read must land first or the read returns stale data.
    if (wb_req && dc_req && (wb_addr == dc_addr)) begin
      grant = GNT_WB;
    end else if (wb_req && wb_full && (starve_cnt == CNT_W'(STARVE_MAX))) begin
      grant = GNT_WB;
    end else if (dc_req) begin
      grant = GNT_DC;
    end else if (ic_req) begin
      grant = GNT_IC;
    end else if (wb_req) begin
      grant = GNT_WB;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the line-wide memory port between I-miss, D-miss and write drain
module mem_port_arbiter
  import dsd_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               proc_reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_e           state_q;
  state_e           state_d;
  gnt_e             grant;
  logic [CNT_W-1:0] starve_cnt;
  logic             rd_grant;

  mem_arb_pick #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .ic_req     (bus.ic_req),
    .dc_req     (bus.dc_req),
    .wb_req     (bus.wb_req),
    .dc_addr    (bus.dc_addr),
    .wb_addr    (bus.wb_addr),
    .wb_full    (bus.wb_full),
    .starve_cnt (starve_cnt),
    .grant      (grant)
  );

  assign rd_grant = (grant == GNT_DC) || (grant == GNT_IC);

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        case (grant)
          GNT_DC:  state_d = RD_D;
          GNT_IC:  state_d = RD_I;
          GNT_WB:  state_d = WR;
          default: state_d = IDLE;
        endcase
      end
      RD_D, RD_I, WR: if (bus.mem_ready) state_d = RESP;
      // RESP lets the served requester drop its level request before re-arbitration.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      starve_cnt    <= '0;
      bus.ic_ready  <= 1'b0;
      bus.ic_rdata  <= '0;
      bus.dc_ready  <= 1'b0;
      bus.dc_rdata  <= '0;
      bus.wb_ack    <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.ic_ready <= 1'b0;
      bus.dc_ready <= 1'b0;
      bus.wb_ack   <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((grant == GNT_WB) || !bus.wb_full) begin
            starve_cnt <= '0;
          end else if (rd_grant && bus.wb_req && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          case (grant)
            GNT_DC: begin
              bus.mem_addr <= bus.dc_addr;
              bus.mem_read <= 1'b1;
            end
            GNT_IC: begin
              bus.mem_addr <= bus.ic_addr;
              bus.mem_read <= 1'b1;
            end
            GNT_WB: begin
              bus.mem_addr  <= bus.wb_addr;
              bus.mem_wdata <= bus.wb_wdata;
              bus.mem_write <= 1'b1;
            end
            default: ;
          endcase
        end
        RD_D, RD_I, WR: begin
          if (bus.mem_ready) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.ic_ready  <= (state_q == RD_I);
            bus.dc_ready  <= (state_q == RD_D);
            bus.wb_ack    <= (state_q == WR);
            if (state_q == RD_I) bus.ic_rdata <= bus.mem_rdata;
            if (state_q == RD_D) bus.dc_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

  localparam int AW    = 28;
  localparam int LW    = 128;
  localparam int SMAX  = 4;
  localparam int NCYC  = 4000;

  localparam int OWN_NONE = 0;
  localparam int OWN_DC   = 1;
  localparam int OWN_IC   = 2;
  localparam int OWN_WB   = 3;

  logic clk = 1'b0;
  logic proc_reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // model: who owns the port, whether the response cycle is pending, starvation tally
  int          owner;
  bit          resp_due;
  int          starve;
  bit          e_read, e_write, e_ic_ready, e_dc_ready, e_wb_ack;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wdata, e_ic_rdata, e_dc_rdata;

  int p_rd, p_wb, p_full;
  int wait_cnt;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_step();
    int win;
    e_ic_ready = 1'b0;
    e_dc_ready = 1'b0;
    e_wb_ack   = 1'b0;
    if (proc_reset) begin
      owner = OWN_NONE; resp_due = 1'b0; starve = 0;
      e_read = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
      e_ic_rdata = '0; e_dc_rdata = '0;
    end else if (resp_due) begin
      resp_due = 1'b0;
      owner    = OWN_NONE;
    end else if (owner == OWN_NONE) begin
      if (bus.wb_req && bus.dc_req && bus.wb_addr == bus.dc_addr)  win = OWN_WB;
      else if (bus.wb_req && bus.wb_full && starve == SMAX)        win = OWN_WB;
      else if (bus.dc_req)                                         win = OWN_DC;
      else if (bus.ic_req)                                         win = OWN_IC;
      else if (bus.wb_req)                                         win = OWN_WB;
      else                                                         win = OWN_NONE;
      if (win == OWN_WB || !bus.wb_full) starve = 0;
      else if ((win == OWN_DC || win == OWN_IC) && bus.wb_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
      owner = win;
      case (win)
        OWN_DC: begin e_addr = bus.dc_addr; e_read = 1'b1; end
        OWN_IC: begin e_addr = bus.ic_addr; e_read = 1'b1; end
        OWN_WB: begin e_addr = bus.wb_addr; e_wdata = bus.wb_wdata; e_write = 1'b1; end
        default: ;
      endcase
    end else if (bus.mem_ready) begin
      e_read   = 1'b0;
      e_write  = 1'b0;
      resp_due = 1'b1;
      case (owner)
        OWN_DC:  begin e_dc_ready = 1'b1; e_dc_rdata = bus.mem_rdata; end
        OWN_IC:  begin e_ic_ready = 1'b1; e_ic_rdata = bus.mem_rdata; end
        default: e_wb_ack = 1'b1;
      endcase
    end
  endtask

  initial begin
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_addr = '0;
    bus.wb_req = 1'b0; bus.wb_addr = '0; bus.wb_wdata = '0; bus.wb_full = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    wait_cnt = 2;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("mem_read",  bus.mem_read,  e_read);
        chk("mem_write", bus.mem_write, e_write);
        chk("mem_excl",  bus.mem_read & bus.mem_write, 1'b0);
        chk("mem_addr",  bus.mem_addr,  e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("ic_ready",  bus.ic_ready,  e_ic_ready);
        chk("dc_ready",  bus.dc_ready,  e_dc_ready);
        chk("wb_ack",    bus.wb_ack,    e_wb_ack);
        chk("ic_rdata",  bus.ic_rdata,  e_ic_rdata);
        chk("dc_rdata",  bus.dc_rdata,  e_dc_rdata);
      end

      // second half: write buffer always full with heavy read traffic to force starvation grants
      if (cyc < NCYC / 2) begin p_rd = 30; p_wb = 20; p_full = 30;  end
      else                begin p_rd = 70; p_wb = 60; p_full = 100; end

      proc_reset = (cyc < 2) || ((bus.mem_read || bus.mem_write) && $urandom_range(0, 199) == 0);

      if (bus.dc_req && bus.dc_ready) bus.dc_req = 1'b0;
      else if (!bus.dc_req && $urandom_range(0, 99) < p_rd) begin
        bus.dc_req  = 1'b1;
        bus.dc_addr = AW'($urandom_range(0, 3));
      end
      if (bus.ic_req && bus.ic_ready) bus.ic_req = 1'b0;
      else if (!bus.ic_req && $urandom_range(0, 99) < p_rd) begin
        bus.ic_req  = 1'b1;
        bus.ic_addr = AW'($urandom_range(16, 19));
      end
      if (bus.wb_req && bus.wb_ack) bus.wb_req = 1'b0;
      else if (!bus.wb_req && $urandom_range(0, 99) < p_wb) begin
        bus.wb_req   = 1'b1;
        bus.wb_addr  = AW'($urandom_range(0, 3));
        bus.wb_wdata = rand_line();
      end
      bus.wb_full = bus.wb_req && ($urandom_range(0, 99) < p_full);

      if (bus.mem_read || bus.mem_write) begin
        if (wait_cnt == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rand_line();
          wait_cnt      = $urandom_range(0, 3);
        end else begin
          bus.mem_ready = 1'b0;
          wait_cnt--;
        end
      end else begin
        bus.mem_ready = ($urandom_range(0, 9) == 0);
        bus.mem_rdata = rand_line();
      end

      model_step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 128-bit memory port between the I-cache read-miss path, the D-cache read-miss path and the D-cache write buffer drain. Read misses take priority over write-buffer drains. Two exceptions override this: an address hazard, and a starvation limit when the write buffer is full. The block sits between the cache wrappers and the external memory interface and owns every mem_* output.

Parameters:
ADDR_W, 28, line address width (matches mem_addr)
LINE_W, 128, cache line width
STARVE_MAX, 4, consecutive read grants allowed while wb_full before a forced write grant

Ports:
clk  input  1  system clock
proc_reset  input  1  synchronous active-high reset
ic_req  input  1  I-cache read-miss request, level, held until ic_ready
ic_addr  input  ADDR_W  I-cache line address
ic_ready  output  1  one-cycle completion pulse to I-cache
ic_rdata  output  LINE_W  line data, valid while ic_ready
dc_req  input  1  D-cache read-miss request, level, held until dc_ready
dc_addr  input  ADDR_W  D-cache line address
dc_ready  output  1  one-cycle completion pulse to D-cache
dc_rdata  output  LINE_W  line data, valid while dc_ready
wb_req  input  1  write buffer has an entry to drain, level
wb_addr  input  ADDR_W  head-entry line address
wb_wdata  input  LINE_W  head-entry line data
wb_full  input  1  write buffer full
wb_ack  output  1  one-cycle pulse: head entry written, pop it
mem_read  output  1  memory read strobe, held until mem_ready
mem_write  output  1  memory write strobe, held until mem_ready
mem_addr  output  ADDR_W  memory line address
mem_wdata  output  LINE_W  memory write data
mem_rdata  input  LINE_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion, one-cycle pulse

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. Reset sets state to IDLE and clears starve_cnt.
- Reset mid-transaction abandons the transaction: no ready or ack is issued.
- States are IDLE, RD_D, RD_I, WR and RESP.
- IDLE arbitration, first match wins:
  1. Hazard: wb_req && dc_req && wb_addr==dc_addr -> WR.
  2. Starvation: wb_req && wb_full && starve_cnt==STARVE_MAX -> WR.
  3. dc_req -> RD_D.
  4. ic_req -> RD_I.
  5. wb_req -> WR.
  6. Otherwise stay in IDLE.
- On the grant edge, latch the winner's address (and data for WR) into mem_addr/mem_wdata. Assert mem_read or mem_write from the next cycle.
- Latency: request seen in IDLE at cycle t -> strobe high at t+1.
- RD_D/RD_I/WR: hold the strobe, mem_addr and mem_wdata stable until mem_ready.
- On mem_ready at cycle k:
  - Go to RESP and deassert the strobe at k+1.
  - At k+1, pulse the matching ready/ack for exactly one cycle.
  - For reads, register mem_rdata into ic_rdata/dc_rdata at the same k+1.
- RESP -> IDLE unconditionally. This gives requesters one cycle to drop req, so no double grant.
- Minimum occupancy per transaction is IDLE, access, RESP = 3 cycles with zero-wait memory.
- mem_ready outside RD_*/WR is ignored.
- Requests changing while not granted have no effect until the next IDLE.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments on each read grant while wb_req && wb_full, saturating at STARVE_MAX.
  - Clears on any WR grant, or whenever wb_full==0 in IDLE.
- Only one of mem_read/mem_write is ever high.
- The mem_* strobes are never asserted in IDLE or RESP.
- rdata outputs hold their last value outside the ready pulses.

Decomposition:
- Shared package dsd_mem_pkg holds:
  - state encoding: IDLE=0, RD_D=1, RD_I=2, WR=3, RESP=4, 3 bits;
  - ADDR_W/LINE_W defaults;
  - a grant-type enum: GNT_NONE, GNT_DC, GNT_IC, GNT_WB.
- Sub-module mem_arb_pick: purely combinational priority/hazard/starvation selector.
  - Inputs: requests, addresses, wb_full, starve_cnt.
  - Output: grant-type.
- The top level holds the FSM, latches, counter and output registers.

Test Plan:
- Single D read: dc_req, dc_addr=0x0000123, mem_ready 2 cycles after mem_read with mem_rdata=0xA5..A5 -> mem_read high from t+1 to ready; dc_ready one pulse with dc_rdata=0xA5..A5; no second mem_read.
- Simultaneous ic_req (0x10) and dc_req (0x20), both held -> D read on 0x20 first, then I read on 0x10; ic_ready never before dc_ready.
- Hazard: wb_req with wb_addr=0x40 and wb_wdata=0x1234..., plus dc_req with dc_addr=0x40 -> mem_write to 0x40 first; wb_ack pulse; then mem_read to 0x40.
- Starvation: wb_full=1 and wb_req held while dc_req is re-raised 6 times, STARVE_MAX=4 -> exactly 4 reads, then one write, then reads resume.
- Reset mid-read: proc_reset for one cycle while mem_read is high -> next cycle all outputs 0 and state IDLE; no dc_ready even if mem_ready arrives afterwards.
- Idle/stray ready: no requests, mem_ready pulsed -> no strobes and no ready/ack outputs.
